div_issue_ctrl: RTL

- Requester-side controller for the 32-bit unsigned iterative divider core. Accepts RISC-V M-extension divide requests (DIV/DIVU/REM/REMU) from the execute stage and drives the core's start/ready/valid/error handshake.
- Converts signed operands to magnitudes and restores signs on the result.
- Resolves divide-by-zero and signed overflow without starting the core.
- Holds a last-result cache so a DIV/REM pair on the same operands uses the core only once.

---
 rtl/div_issue_ctrl_pkg.sv | 42 ++++
 rtl/div_sign_fix.sv | 19 +
 rtl/div_issue_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings, constants and small arithmetic helpers for the divide issue controller.
package div_issue_ctrl_pkg;

  // RISC-V M-extension divide flavours as carried on req_op.
  typedef enum logic [1:0] {
    OpDiv  = 2'd0,
    OpDivu = 2'd1,
    OpRem  = 2'd2,
    OpRemu = 2'd3
  } div_op_e;

  // Controller states; the three spare encodings recover to StIdle.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } div_state_e;

  localparam logic [31:0] IntMin  = 32'h8000_0000;
  localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(div_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

  // Two's-complement negation, wrapping mod 2^32.
  function automatic logic [31:0] neg32(logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude for the unsigned core; abs(INT_MIN) stays 0x8000_0000 as an unsigned value.
  function automatic logic [31:0] mag32(logic [31:0] v, logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Restores RISC-V signs on unsigned quotient/remainder magnitudes from the divider core.
module div_sign_fix
  import div_issue_ctrl_pkg::*;
(
  input  logic [31:0] quot_mag,
  input  logic [31:0] rem_mag,
  input  logic        neg_quot,
  input  logic        neg_rem,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  // Conditional negation of each magnitude.
  always_comb begin
    quot = neg_quot ? neg32(quot_mag) : quot_mag;
    rem  = neg_rem  ? neg32(rem_mag)  : rem_mag;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Requester-side controller for the 32-bit unsigned iterative divider core: handles signs,
// divide-by-zero and overflow fast paths, and a last-operand result cache.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter bit ENABLE_CACHE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  input  logic        flush,
  output logic        core_start,
  output logic [31:0] core_dividend,
  output logic [31:0] core_divisor,
  input  logic        core_ready,
  input  logic        core_valid,
  input  logic        core_error,
  input  logic [31:0] core_quotient,
  input  logic [31:0] core_remainder
);

  div_state_e  state_q, state_d;
  logic [31:0] res_q, res_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;

  // Request context kept while the core works.
  logic [31:0] a_q, b_q;
  logic        signed_q, is_rem_q, neg_quot_q, neg_rem_q;

  // Last-result cache.
  logic        cache_vld_q;
  logic [31:0] cache_a_q, cache_b_q, cache_quot_q, cache_rem_q;
  logic        cache_signed_q;

  logic        capture_req;
  logic        cache_fill;

  // Request decode.
  div_op_e     op;
  logic        req_signed, req_is_rem, req_neg_quot, req_neg_rem;
  logic        b_zero, ovf, cache_hit;
  logic [31:0] a_mag, b_mag;
  logic [31:0] fix_quot, fix_rem;

  // Decode the offered request and evaluate the fast-path conditions.
  always_comb begin
    op           = div_op_e'(req_op);
    req_signed   = op_is_signed(op);
    req_is_rem   = op_is_rem(op);
    a_mag        = mag32(req_a, req_signed);
    b_mag        = mag32(req_b, req_signed);
    req_neg_quot = req_signed && (req_a[31] ^ req_b[31]);
    req_neg_rem  = req_signed && req_a[31];
    b_zero       = (req_b == '0);
    ovf          = req_signed && (req_a == IntMin) && (req_b == AllOnes);
    cache_hit    = ENABLE_CACHE && cache_vld_q && (cache_a_q == req_a) &&
                   (cache_b_q == req_b) && (cache_signed_q == req_signed);
  end

  // One sign-fix instance feeds both the response and the cache fill.
  div_sign_fix u_sign_fix (
    .quot_mag (core_quotient),
    .rem_mag  (core_remainder),
    .neg_quot (neg_quot_q),
    .neg_rem  (neg_rem_q),
    .quot     (fix_quot),
    .rem      (fix_rem)
  );

  // Next-state, response and core-operand selection.
  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    capture_req = 1'b0;
    cache_fill  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          state_d = StDone;
          if (b_zero) begin
            res_d = req_is_rem ? req_a : AllOnes;
          end else if (ovf) begin
            res_d = req_is_rem ? '0 : IntMin;
          end else if (cache_hit) begin
            res_d = req_is_rem ? cache_rem_q : cache_quot_q;
          end else begin
            dvd_d       = a_mag;
            dvs_d       = b_mag;
            capture_req = 1'b1;
            state_d     = StIssue;
          end
        end
      end
      StIssue: begin
        // core_ready high means the core samples start this cycle and cannot be aborted.
        if (flush) begin
          state_d = core_ready ? StDrain : StIdle;
        end else if (core_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (core_valid) begin
          cache_fill = !core_error;
          if (flush) begin
            state_d = StIdle;
          end else begin
            if (core_error) begin
              res_d = is_rem_q ? a_q : AllOnes;
            end else begin
              res_d = is_rem_q ? fix_rem : fix_quot;
            end
            state_d = StDone;
          end
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (core_valid) begin
          cache_fill = !core_error;
          state_d    = StIdle;
        end
      end
      StDone: begin
        if (flush || resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, response and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      res_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      signed_q   <= 1'b0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      if (capture_req) begin
        a_q        <= req_a;
        b_q        <= req_b;
        signed_q   <= req_signed;
        is_rem_q   <= req_is_rem;
        neg_quot_q <= req_neg_quot;
        neg_rem_q  <= req_neg_rem;
      end
    end
  end

  // Cache update on every good core result, including drained ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_q    <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_signed_q <= 1'b0;
      cache_quot_q   <= '0;
      cache_rem_q    <= '0;
    end else if (ENABLE_CACHE && cache_fill) begin
      cache_vld_q    <= 1'b1;
      cache_a_q      <= a_q;
      cache_b_q      <= b_q;
      cache_signed_q <= signed_q;
      cache_quot_q   <= fix_quot;
      cache_rem_q    <= fix_rem;
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready     = (state_q == StIdle) && !flush;
    resp_valid    = (state_q == StDone);
    core_start    = (state_q == StIssue);
    resp_result   = res_q;
    core_dividend = dvd_q;
    core_divisor  = dvs_q;
  end

endmodule
